// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the CPU datapath and a word-wide, registered-read d_mem.
// Sub-word stores are handled as read-modify-write; misaligned or out-of-range requests return an error.
module mem_access_ctrl #(
    parameter int MemSize = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        mem_read,
    output logic        mem_write
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    // Request fields latched on accept; they only matter while the request is in flight.
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        req_err;

    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_format = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_format = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_format = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wd,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] w;
        w = word;
        if (size == 2'b00) begin
            w[{lane, 3'b000} +: 8] = wd[7:0];
        end else begin
            w[{lane[1], 4'b0000} +: 16] = wd;
        end
        store_merge = w;
    endfunction

    assign accept  = req_valid && (state_q == S_IDLE);
    assign req_err = (req_size == 2'b11)
                  || ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                  || ((req_addr >> (MemSize + 2)) != 32'd0);

    always_comb begin
        state_d          = state_q;
        resp_err_d       = 1'b0;
        resp_rdata_d     = resp_rdata_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mem_address_d = {2'b00, req_addr[31:2]};
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (req_write && (req_size == 2'b10)) begin
                        state_d          = S_WR;
                        mem_write_data_d = req_wdata;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_CAP;
            // ReadData is only valid during this cycle, so it is consumed here either way.
            S_CAP: begin
                if (write_q) begin
                    state_d          = S_WR;
                    mem_write_data_d = store_merge(mem_read_data, wdata_q, size_q, lane_q);
                end else begin
                    state_d      = S_RESP;
                    resp_rdata_d = load_format(mem_read_data, size_q, lane_q, unsigned_q);
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_rdata_d = 32'd0;
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        mem_read_d   = (state_d == S_RD);
        mem_write_d  = (state_d == S_WR);
        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= 32'd0;
            mem_address_q    <= 32'd0;
            mem_write_data_q <= 32'd0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata[15:0];
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural registered-read d_mem model.
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read;
    logic        mem_write;

    logic [31:0] dmem [32];

    int n_checks = 0;
    int n_errors = 0;

    mem_access_ctrl #(.MemSize(5)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // d_mem: registered read, ReadData cleared on any edge without MemRead.
    always @(posedge clock) begin
        if (mem_write) dmem[mem_address[4:0]] <= mem_write_data;
        if (mem_read) mem_read_data <= dmem[mem_address[4:0]];
        else          mem_read_data <= 32'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // lat = negedges after the accept edge until resp_valid is seen (1 err, 2 SW, 3 load, 4 SB/SH).
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, input logic err, input logic [31:0] rdata);
        int          got_lat;
        int          n_rd;
        int          n_wr;
        int          wr_k;
        int          both;
        logic [31:0] strobe_addr;
        logic        got_err;
        logic [31:0] got_rdata;
        got_lat = 0; n_rd = 0; n_wr = 0; wr_k = 0; both = 0;
        strobe_addr = 32'd0; got_err = 1'b0; got_rdata = 32'hxxxxxxxx;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = addr; req_wdata = wd;
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) req_valid = 1'b0;
            if (mem_read && mem_write) both++;
            if (mem_read) begin n_rd++; strobe_addr = mem_address; end
            if (mem_write) begin
                n_wr++;
                if (wr_k == 0) wr_k = k;
                strobe_addr = mem_address;
            end
            if (resp_valid) begin
                got_lat = k; got_err = resp_err; got_rdata = resp_rdata;
                break;
            end
        end
        chk({tag, " latency"}, got_lat, lat);
        chk({tag, " err"}, {31'd0, got_err}, {31'd0, err});
        chk({tag, " rdata"}, got_rdata, rdata);
        chk({tag, " reads"}, n_rd, (lat == 3 || lat == 4) ? 1 : 0);
        chk({tag, " writes"}, n_wr, (lat == 2 || lat == 4) ? 1 : 0);
        chk({tag, " write cycle"}, wr_k, (lat == 2) ? 1 : (lat == 4) ? 3 : 0);
        chk({tag, " strobe overlap"}, both, 0);
        chk({tag, " address"}, strobe_addr, (lat == 1) ? 32'd0 : {2'b00, addr[31:2]});
        @(negedge clock);
        chk({tag, " pulse"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " hold"}, resp_rdata, rdata);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) dmem[i] = 32'd0;
        mem_read_data = 32'd0;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst address", mem_address, 32'd0);
        chk("rst wdata", mem_write_data, 32'd0);

        do_req("SW 08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 2, 1'b0, 32'd0);
        chk("mem after SW", dmem[2], 32'hDEADBEEF);
        do_req("LW 08", 1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 3, 1'b0, 32'hDEADBEEF);
        do_req("SB 0B", 1'b1, 2'b00, 1'b0, 32'h0B, 32'hAAAAAA80, 4, 1'b0, 32'd0);
        chk("mem after SB", dmem[2], 32'h80ADBEEF);
        do_req("LB 0B", 1'b0, 2'b00, 1'b0, 32'h0B, 32'd0, 3, 1'b0, 32'hFFFFFF80);
        do_req("LBU 0B", 1'b0, 2'b00, 1'b1, 32'h0B, 32'd0, 3, 1'b0, 32'h00000080);
        do_req("LB 09", 1'b0, 2'b00, 1'b0, 32'h09, 32'd0, 3, 1'b0, 32'hFFFFFFBE);
        do_req("SH 0A", 1'b1, 2'b01, 1'b0, 32'h0A, 32'hFFFF1234, 4, 1'b0, 32'd0);
        chk("mem after SH", dmem[2], 32'h1234BEEF);
        do_req("LH 0A", 1'b0, 2'b01, 1'b0, 32'h0A, 32'd0, 3, 1'b0, 32'h00001234);
        do_req("LHU 08", 1'b0, 2'b01, 1'b1, 32'h08, 32'd0, 3, 1'b0, 32'h0000BEEF);
        do_req("LH 08", 1'b0, 2'b01, 1'b0, 32'h08, 32'd0, 3, 1'b0, 32'hFFFFBEEF);
        do_req("SB 04", 1'b1, 2'b00, 1'b0, 32'h04, 32'h000000A5, 4, 1'b0, 32'd0);
        chk("mem after SB 04", dmem[1], 32'h000000A5);
        chk("mem 2 untouched", dmem[2], 32'h1234BEEF);
        do_req("SW 7C", 1'b1, 2'b10, 1'b0, 32'h7C, 32'h0BADF00D, 2, 1'b0, 32'd0);
        do_req("LW 7C", 1'b0, 2'b10, 1'b0, 32'h7C, 32'd0, 3, 1'b0, 32'h0BADF00D);

        do_req("LW 06", 1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 1, 1'b1, 32'd0);
        do_req("LH 03", 1'b0, 2'b01, 1'b0, 32'h03, 32'd0, 1, 1'b1, 32'd0);
        do_req("size 11", 1'b0, 2'b11, 1'b0, 32'h08, 32'd0, 1, 1'b1, 32'd0);
        do_req("LW 80", 1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 1, 1'b1, 32'd0);
        do_req("SB 80", 1'b1, 2'b00, 1'b0, 32'h80, 32'h000000FF, 1, 1'b1, 32'd0);
        chk("mem 0 after bad SB", dmem[0], 32'd0);

        // Reset while the load sits in RD: the request must vanish without a response.
        begin
            int n_resp;
            n_resp = 0;
            @(negedge clock);
            req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h08;
            @(posedge clock);
            @(negedge clock);
            req_valid = 1'b0;
            chk("midrd read strobe", {31'd0, mem_read}, 32'd1);
            reset_n = 1'b0;
            repeat (2) @(posedge clock);
            @(negedge clock);
            reset_n = 1'b1;
            chk("midrd ready", {31'd0, req_ready}, 32'd1);
            chk("midrd strobes", {30'd0, mem_read, mem_write}, 32'd0);
            for (int k = 0; k < 6; k++) begin
                if (resp_valid) n_resp++;
                @(negedge clock);
            end
            chk("midrd no resp", n_resp, 0);
        end

        // req_valid held high across SW then LW.
        begin
            int          n_resp;
            int          both;
            int          r1_k;
            int          r2_k;
            logic [31:0] r1_d;
            logic [31:0] r2_d;
            logic        rdy2;
            logic        rdy3;
            n_resp = 0; both = 0; r1_k = 0; r2_k = 0;
            r1_d = 32'hxxxxxxxx; r2_d = 32'hxxxxxxxx; rdy2 = 1'b1; rdy3 = 1'b0;
            @(negedge clock);
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
            req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
            @(posedge clock);
            for (int k = 1; k <= 12; k++) begin
                @(negedge clock);
                if (k == 1) begin req_write = 1'b0; req_wdata = 32'd0; end
                if (k == 2) rdy2 = req_ready;
                if (k == 3) rdy3 = req_ready;
                if (k == 4) req_valid = 1'b0;
                if (mem_read && mem_write) both++;
                if (resp_valid) begin
                    n_resp++;
                    if (n_resp == 1) begin r1_k = k; r1_d = resp_rdata; end
                    else if (n_resp == 2) begin r2_k = k; r2_d = resp_rdata; end
                end
            end
            chk("b2b responses", n_resp, 2);
            chk("b2b resp1 cycle", r1_k, 2);
            chk("b2b resp1 rdata", r1_d, 32'd0);
            chk("b2b ready in RESP", {31'd0, rdy2}, 32'd0);
            chk("b2b ready after RESP", {31'd0, rdy3}, 32'd1);
            chk("b2b resp2 cycle", r2_k, 6);
            chk("b2b resp2 rdata", r2_d, 32'hCAFEF00D);
            chk("b2b strobe overlap", both, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
